// File: rtl/turbo_pkg.sv
// Shared definitions for the rate-1/3 PCCC turbo encoder: FSM encoding and
// the (7,5)oct recursive systematic convolutional code description.
package turbo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_ENC   = 3'd2,
        ST_TERM1 = 3'd3,
        ST_TERM2 = 3'd4
    } state_t;

    // Generator taps, MSB = current input/feedback node, LSB = oldest state bit.
    localparam logic [2:0] FB = 3'b111;
    localparam logic [2:0] FF = 3'b101;

    typedef struct packed {
        logic s1;
        logic s0;
    } rsc_state_t;

    // Feedback contribution of the shift register (input tap FB[2] is implicit).
    function automatic logic rsc_feedback(input rsc_state_t s);
        return (FB[1] & s.s1) ^ (FB[0] & s.s0);
    endfunction

    function automatic logic rsc_parity(input logic a, input rsc_state_t s);
        return (FF[2] & a) ^ (FF[1] & s.s1) ^ (FF[0] & s.s0);
    endfunction

endpackage

// File: rtl/rsc_encoder.sv
// One 4-state recursive systematic convolutional encoder. Parity is combinational
// from the current state; the state advances only when step is asserted.
module rsc_encoder
    import turbo_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic step,
    input  logic term,
    input  logic u,
    output logic parity,
    output logic sys_eff
);

    rsc_state_t st;
    logic       a;

    // NOTE: every combinational output gets a value on every path, so no latch is inferred.
    always_comb begin
        // Termination feeds back the register contents so the feedback node becomes 0.
        sys_eff = term ? rsc_feedback(st) : u;
        a       = sys_eff ^ rsc_feedback(st);
        parity  = rsc_parity(a, st);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st <= '0;
        end else if (step) begin
            st <= '{s1: a, s0: st.s1};
        end
    end

endmodule

// File: rtl/turbo_encoder.sv
// Rate-1/3 PCCC turbo encoder: buffers an N-bit frame, then streams
// systematic/RSC1/RSC2 triples followed by 2+2 trellis-termination triples.
module turbo_encoder
    import turbo_pkg::*;
#(
    parameter int N      = 40,
    parameter int PERM_P = 13,
    parameter int CW     = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_ready,
    input  logic in_bit,
    output logic out_valid,
    input  logic out_ready,
    output logic out_sys,
    output logic out_par1,
    output logic out_par2,
    output logic out_tail,
    output logic out_last
);

    localparam int AW = (N > 1) ? $clog2(N) : 1;

    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] N_LAST    = CW'(N - 1);
    localparam logic [CW-1:0] N_CNT     = CW'(N);
    localparam logic [CW-1:0] TAIL_LAST = CW'(2);

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] cnt;
    logic [AW-1:0] ia;
    logic [N-1:0]  bit_buf;

    logic          accept_in;
    logic          accept_out;
    logic          fill_done;
    logic          frame_done;
    logic          load;
    logic          load_last;
    logic          rsc1_step;
    logic          rsc1_term;
    logic          rsc2_step;
    logic          rsc2_term;

    logic [AW-1:0] rd_idx;
    logic [AW:0]   ia_sum;
    logic [AW-1:0] ia_next;
    logic          u1;
    logic          u2;
    logic          par1;
    logic          par2;
    logic          sys1;
    logic          sys2;

    assign in_ready   = (state == ST_FILL);
    assign accept_in  = in_valid && (state == ST_FILL);
    assign accept_out = out_valid && out_ready;
    assign fill_done  = accept_in && (cnt == N_LAST);
    // The last TERM2 triple leaves the pipe empty instead of loading a new one.
    assign frame_done = (state == ST_TERM2) && accept_out && (cnt == TAIL_LAST);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ---------------- FSM: next state ----------------
    // The state names the phase of the triple currently on the output register.
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE:  next_state = ST_FILL;
            ST_FILL:  if (fill_done) next_state = ST_ENC;
            ST_ENC:   if (accept_out && (cnt == N_CNT)) next_state = ST_TERM1;
            ST_TERM1: if (accept_out && (cnt == TAIL_LAST)) next_state = ST_TERM2;
            ST_TERM2: if (accept_out && (cnt == TAIL_LAST)) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        load      = fill_done || (accept_out && !frame_done);
        load_last = (state == ST_TERM2);
        rsc1_term = (next_state == ST_TERM1);
        rsc2_term = (next_state == ST_TERM2);
        rsc1_step = load && ((next_state == ST_ENC) || (next_state == ST_TERM1));
        rsc2_step = load && ((next_state == ST_ENC) || (next_state == ST_TERM2));
    end

    // ---------------- Bit buffer and interleaver address ----------------
    always_comb begin
        rd_idx  = (state == ST_FILL) ? '0 : cnt[AW-1:0];
        u1      = bit_buf[rd_idx];
        u2      = bit_buf[ia];
        ia_sum  = {1'b0, ia} + (AW+1)'(PERM_P);
        ia_next = (ia_sum >= (AW+1)'(N)) ? AW'(ia_sum - (AW+1)'(N)) : ia_sum[AW-1:0];
    end

    // NOTE: the frame buffer has no reset; FILL rewrites every entry before any is read.
    always_ff @(posedge clk) begin
        if (accept_in) begin
            bit_buf[cnt[AW-1:0]] <= in_bit;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            ia  <= '0;
        end else begin
            if (next_state != state) begin
                cnt <= (next_state inside {ST_ENC, ST_TERM1, ST_TERM2}) ? CNT_ONE : '0;
            end else if (accept_in || accept_out) begin
                cnt <= cnt + CNT_ONE;
            end

            if (state == ST_IDLE) begin
                ia <= '0;
            end else if (load && (next_state == ST_ENC)) begin
                ia <= ia_next;
            end
        end
    end

    // ---------------- Constituent encoders ----------------
    rsc_encoder u_rsc1 (
        .clk     (clk),
        .rst     (rst),
        .step    (rsc1_step),
        .term    (rsc1_term),
        .u       (u1),
        .parity  (par1),
        .sys_eff (sys1)
    );

    rsc_encoder u_rsc2 (
        .clk     (clk),
        .rst     (rst),
        .step    (rsc2_step),
        .term    (rsc2_term),
        .u       (u2),
        .parity  (par2),
        .sys_eff (sys2)
    );

    // ---------------- Output register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_sys   <= 1'b0;
            out_par1  <= 1'b0;
            out_par2  <= 1'b0;
            out_tail  <= 1'b0;
            out_last  <= 1'b0;
        end else if (frame_done) begin
            out_valid <= 1'b0;
            out_sys   <= 1'b0;
            out_par1  <= 1'b0;
            out_par2  <= 1'b0;
            out_tail  <= 1'b0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_sys   <= (next_state == ST_TERM2) ? sys2 : sys1;
            out_par1  <= (next_state == ST_TERM2) ? 1'b0 : par1;
            out_par2  <= (next_state == ST_TERM1) ? 1'b0 : par2;
            out_tail  <= (next_state != ST_ENC);
            out_last  <= load_last;
        end
    end

endmodule
